// File: rtl/key_matrix_scan_pkg.sv
// rtl/key_matrix_scan_pkg.sv - shared FSM states, column constants and key-code helpers for the key matrix scanner
package key_matrix_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  // Column drive is one-hot-low; column 0 is the first one driven after reset
  localparam logic [3:0] COL_RESET  = 4'b1110;
  localparam int         KEY_CODE_W = 4;

  // Next column in the 1110 -> 1101 -> 1011 -> 0111 rotation
  function automatic logic [3:0] col_next(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

  // Index of the driven (low) column
  function automatic logic [1:0] col_index(input logic [3:0] col);
    case (col)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Lowest-index row that reads low; only meaningful when some row is low
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0]) return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else return 2'd3;
  endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// rtl/key_matrix_scan_if.sv - key report handshake between the scanner and its consumer
interface key_matrix_scan_if;
  import key_matrix_scan_pkg::*;

  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_valid;
  logic                  key_ack;
  logic                  overrun;

  modport master (output key_code, output key_valid, output overrun, input key_ack);
  modport slave  (input key_code, input key_valid, input overrun, output key_ack);
endinterface

// File: rtl/key_matrix_scan_debounce.sv
// rtl/key_matrix_scan_debounce.sv - key_debounce: row synchronizer plus consecutive-level stability counter
module key_debounce #(
  parameter int STABLE_CNT = 540000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  input  logic [1:0] sel,
  input  logic       level,
  input  logic       run,
  output logic [3:0] rs,
  output logic       done
);
  localparam int            CW       = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match;

  assign rs    = sync2_q;
  assign match = run && (sync2_q[sel] == level);
  // done marks the STABLE_CNT-th consecutive clock at the wanted level
  assign done  = match && (cnt_q == CNT_LAST);

  // Two-stage sync of the asynchronous rows; the counter restarts on any mismatch or when idle
  always_comb begin
    sync1_d = row_in;
    sync2_d = sync1_q;
    cnt_d   = '0;
    if (match && !done) cnt_d = cnt_q + 1'b1;
  end

  // Rows idle high (released) out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - 4x4 key matrix scanner with debounce and key handshake; define KEY_MATRIX_REPEAT_EN for auto-repeat
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 5400000,
  parameter int DEBOUNCE_CNT = 540000,
  parameter int REPEAT_DLY   = 27000000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [3:0]        col_out,
  input  logic [3:0]        row_in,
  key_matrix_scan_if.master kbd
);
  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  scan_state_e           state_q;
  logic [3:0]            col_q;
  logic [DW-1:0]         dwell_q;
  logic [1:0]            row_q;
  logic [3:0]            rs;
  logic                  db_run, db_level, db_done;
  logic                  sel_bit, dwell_end, press_accept, rpt_fire, accept;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  overrun_q, overrun_d;

  // One stability counter serves both the press (wait for low) and release (wait for high) checks
  key_debounce #(
    .STABLE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .row_in (row_in),
    .sel    (row_q),
    .level  (db_level),
    .run    (db_run),
    .rs     (rs),
    .done   (db_done)
  );

  assign sel_bit      = rs[row_q];
  assign dwell_end    = (dwell_q == DWELL_LAST);
  assign db_run       = (state_q == DEBOUNCE) || (state_q == RELEASE);
  assign db_level     = (state_q == RELEASE);
  assign press_accept = (state_q == DEBOUNCE) && !sel_bit && db_done;
  assign accept       = press_accept || rpt_fire;

`ifdef KEY_MATRIX_REPEAT_EN
  localparam int            RW       = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_DLY - 1);

  logic [RW-1:0] rpt_q, rpt_d;

  assign rpt_fire = (state_q == HELD) && !sel_bit && (rpt_q == RPT_LAST);

  // Count continuous hold time; leaving HELD or a firing restarts the interval
  always_comb begin
    rpt_d = '0;
    if ((state_q == HELD) && !sel_bit && !rpt_fire) rpt_d = rpt_q + 1'b1;
  end

  // Repeat interval register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end
`else
  // Repeat not built; the parameter is still referenced so every build shares one parameter list
  assign rpt_fire = (REPEAT_DLY < 0);
`endif

  // Scan/debounce/hold sequencing, with the column drive registered beside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      col_q   <= COL_RESET;
      dwell_q <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (dwell_end) begin
            dwell_q <= '0;
            if (rs == 4'hF) begin
              col_q <= col_next(col_q);
            end else begin
              row_q   <= lowest_low(rs);
              state_q <= DEBOUNCE;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (sel_bit) begin
            state_q <= SCAN;
            col_q   <= col_next(col_q);
          end else if (db_done) begin
            state_q <= HELD;
          end
        end
        HELD: begin
          if (sel_bit) state_q <= RELEASE;
        end
        RELEASE: begin
          if (!sel_bit) begin
            state_q <= HELD;
          end else if (db_done) begin
            state_q <= SCAN;
            col_q   <= col_next(col_q);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  // Handshake: an acceptance wins over a same-clock ack, and only flags overrun if the old key was unacked
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (accept) begin
      key_code_d  = {row_q, col_index(col_q)};
      key_valid_d = 1'b1;
      if (key_valid_q && !kbd.key_ack) overrun_d = 1'b1;
    end else if (kbd.key_ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // Handshake registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col_out       = col_q;
  assign kbd.key_code  = key_code_q;
  assign kbd.key_valid = key_valid_q;
  assign kbd.overrun   = overrun_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - self-checking bench for key_matrix_scan against a behavioural key matrix and report model
module tb_key_matrix_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col_out;
  logic [3:0] row_in;
  logic       pressed = 1'b0;
  logic [3:0] press_key = 4'd0;

  int checks = 0;
  int errors = 0;

  // Report model: accepts since the last ack and the most recent accepted key
  int         pend = 0;
  logic [3:0] last_key = 4'd0;

`ifdef KEY_MATRIX_REPEAT_EN
  localparam int EXP_ACC = 3;
`else
  localparam int EXP_ACC = 1;
`endif

  key_matrix_scan_if kbd_bus ();

  key_matrix_scan #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8),
    .REPEAT_DLY   (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .col_out (col_out),
    .row_in  (row_in),
    .kbd     (kbd_bus)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its row low whenever its column is driven
  always_comb begin
    row_in = 4'hF;
    if (pressed && !col_out[press_key[1:0]]) row_in[press_key[3:2]] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] col_pat(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Return at the first negedge after col_out switches to the given column
  task automatic wait_col(input int idx);
    logic [3:0] prev;
    bit         ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      prev = col_out;
      @(negedge clk);
      if (col_out != prev && col_out == col_pat(idx)) ok = 1'b1;
    end
    check("col_arrival", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, {31'd0, kbd_bus.key_valid}, (pend > 0) ? 32'd1 : 32'd0);
    check({tag, "_overrun"}, {31'd0, kbd_bus.overrun}, (pend > 1) ? 32'd1 : 32'd0);
    check({tag, "_code"}, {28'd0, kbd_bus.key_code}, {28'd0, last_key});
  endtask

  task automatic long_press(input logic [3:0] key);
    press_key = key;
    wait_col(int'(key[1:0]));
    pressed = 1'b1;
    tick(24);
    pressed = 1'b0;
    tick(20);
    pend++;
    last_key = key;
  endtask

  task automatic glitch(input logic [3:0] key, input int k);
    press_key = key;
    wait_col(int'(key[1:0]));
    pressed = 1'b1;
    tick(k);
    pressed = 1'b0;
    tick(20);
  endtask

  task automatic do_ack();
    kbd_bus.key_ack = 1'b1;
    tick(1);
    kbd_bus.key_ack = 1'b0;
    pend = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int nacc;
    int prev_t;
    int op;
    logic [3:0] rkey;

    kbd_bus.key_ack = 1'b0;
    #12;
    check("rst_col", {28'd0, col_out}, 32'hE);
    check("rst_valid", {31'd0, kbd_bus.key_valid}, 32'd0);
    check("rst_overrun", {31'd0, kbd_bus.overrun}, 32'd0);
    check("rst_code", {28'd0, kbd_bus.key_code}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Idle scan: each column for four clocks, starting at column 0
    for (int k = 0; k < 40; k++) begin
      check("idle_col", {28'd0, col_out}, {28'd0, col_pat((k / 4) % 4)});
      @(negedge clk);
    end
    check("idle_valid", {31'd0, kbd_bus.key_valid}, 32'd0);

    // Key 10 held, reported until acked
    long_press(4'd10);
    check_model("key10");
    tick(5);
    check_model("key10_hold");
    do_ack();
    check_model("key10_ack");

    // Short row-1 press: rejected, scan moves on to the next column
    press_key = 4'd5;
    wait_col(1);
    pressed = 1'b1;
    tick(5);
    pressed = 1'b0;
    begin
      bit moved;
      moved = 1'b0;
      for (int i = 0; i < 40 && !moved; i++) begin
        @(negedge clk);
        if (col_out != 4'b1101) moved = 1'b1;
      end
      check("glitch_moved", {31'd0, moved}, 32'd1);
      check("glitch_next_col", {28'd0, col_out}, 32'hB);
    end
    tick(20);
    check_model("glitch");

    // Two presses without ack: second key shown with overrun, ack clears both
    long_press(4'd3);
    long_press(4'd12);
    check_model("overrun");
    do_ack();
    check_model("overrun_ack");

    // Measure press-to-report latency, then ack on exactly the accepting clock of a second key
    press_key = 4'd6;
    wait_col(2);
    pressed = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (kbd_bus.key_valid) begin
        lat = i;
        break;
      end
    end
    check("calib_found", (lat > 0) ? 32'd1 : 32'd0, 32'd1);
    if (lat < 24) tick(24 - lat);
    pressed = 1'b0;
    tick(20);
    pend = 1;
    last_key = 4'd6;
    check_model("calib");
    press_key = 4'd9;
    wait_col(1);
    pressed = 1'b1;
    if (lat > 1) tick(lat - 1);
    kbd_bus.key_ack = 1'b1;
    tick(1);
    kbd_bus.key_ack = 1'b0;
    check("simul_valid", {31'd0, kbd_bus.key_valid}, 32'd1);
    check("simul_overrun", {31'd0, kbd_bus.overrun}, 32'd0);
    check("simul_code", {28'd0, kbd_bus.key_code}, 32'd9);
    if (lat < 24) tick(24 - lat);
    pressed = 1'b0;
    tick(20);
    pend = 1;
    last_key = 4'd9;
    check_model("simul");
    do_ack();
    check_model("simul_ack");

    // Reset in the middle of a debounce discards the key and restarts at column 0
    press_key = 4'd7;
    wait_col(3);
    pressed = 1'b1;
    tick(8);
    reset = 1'b0;
    tick(2);
    check("midrst_col", {28'd0, col_out}, 32'hE);
    check("midrst_valid", {31'd0, kbd_bus.key_valid}, 32'd0);
    check("midrst_overrun", {31'd0, kbd_bus.overrun}, 32'd0);
    check("midrst_code", {28'd0, kbd_bus.key_code}, 32'd0);
    pressed = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("postrst_col", {28'd0, col_out}, {28'd0, col_pat(k / 4)});
      @(negedge clk);
    end
    tick(60);
    pend = 0;
    last_key = 4'd0;
    check_model("postrst");

    // Randomized presses, glitches and acks against the report model
    for (int n = 0; n < 14; n++) begin
      op   = int'($urandom_range(0, 3));
      rkey = 4'($urandom_range(0, 15));
      if (op <= 1) long_press(rkey);
      else if (op == 2) glitch(rkey, int'($urandom_range(1, 5)));
      else do_ack();
      check_model("rand");
    end
    do_ack();
    check_model("rand_ack");

    // Key 0 held 100 clocks with an ack after every report
    press_key = 4'd0;
    wait_col(0);
    pressed = 1'b1;
    nacc = 0;
    prev_t = 0;
    for (int t = 1; t <= 130; t++) begin
      @(negedge clk);
      if (t == 100) pressed = 1'b0;
      if (kbd_bus.key_ack) begin
        kbd_bus.key_ack = 1'b0;
      end else if (kbd_bus.key_valid) begin
        if (nacc > 0) check("repeat_interval", t - prev_t, 32'd32);
        prev_t = t;
        nacc++;
        kbd_bus.key_ack = 1'b1;
      end
    end
    kbd_bus.key_ack = 1'b0;
    check("repeat_count", nacc, EXP_ACC);
    pend = 0;
    last_key = 4'd0;
    check_model("repeat_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
